// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, pipeline control inputs and IF/ID outputs.
// Fetch advances once per enabled edge; there is no valid/ready backpressure, only i_stall/i_enable.
interface instruction_fetch_unit_if #(
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 32
);
  logic                   i_enable;
  logic                   i_stall;
  logic                   i_branch_taken;
  logic [ADDR_LENGTH-1:0] i_branch_target;
  logic                   i_jump;
  logic [ADDR_LENGTH-1:0] i_jump_target;
  logic [ADDR_LENGTH-1:0] o_mem_addr;
  logic [DATA_LENGTH-1:0] i_mem_data;
  logic [DATA_LENGTH-1:0] o_ifid_instr;
  logic [ADDR_LENGTH-1:0] o_ifid_pc_plus4;
  logic                   o_ifid_valid;
  logic [ADDR_LENGTH-1:0] o_pc;
  logic                   o_halted;
  logic [31:0]            o_instr_count;
  logic                   o_fsm_state;

  modport master (
    output i_enable, i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target, i_mem_data,
    input  o_mem_addr, o_ifid_instr, o_ifid_pc_plus4, o_ifid_valid, o_pc, o_halted,
           o_instr_count, o_fsm_state
  );

  modport slave (
    input  i_enable, i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target, i_mem_data,
    output o_mem_addr, o_ifid_instr, o_ifid_pc_plus4, o_ifid_valid, o_pc, o_halted,
           o_instr_count, o_fsm_state
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, instruction memory addressing and IF/ID register with
// stall, redirect flush, debug enable and halt-word detection.
module instruction_fetch_unit #(
  parameter int                     ADDR_LENGTH = 32,
  parameter int                     DATA_LENGTH = 32,
  parameter logic [DATA_LENGTH-1:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter logic [DATA_LENGTH-1:0] NOP_WORD    = 32'h0000_0000
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  instruction_fetch_unit_if.slave bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                 state;
  logic [ADDR_LENGTH-1:0] pc;
  logic [ADDR_LENGTH-1:0] pc_plus4;
  logic [DATA_LENGTH-1:0] ifid_instr;
  logic [ADDR_LENGTH-1:0] ifid_pc_plus4;
  logic                   ifid_valid;
  logic                   halted;
  logic [31:0]            instr_count;
  logic                   redirect;
  logic [ADDR_LENGTH-1:0] redirect_target;

  assign pc_plus4        = pc + ADDR_LENGTH'(4);
  assign redirect        = bus.i_branch_taken | bus.i_jump;
  // Branch has priority over jump when both resolve in the same cycle.
  assign redirect_target = bus.i_branch_taken ? bus.i_branch_target : bus.i_jump_target;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RUN;
      pc            <= '0;
      ifid_instr    <= NOP_WORD;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      halted        <= 1'b0;
      instr_count   <= '0;
    end else if (bus.i_enable) begin
      case (state)
        RUN: begin
          if (redirect) begin
            // Word-align the target and flush the wrong-path fetch.
            pc         <= {redirect_target[ADDR_LENGTH-1:2], 2'b00};
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
          end else if (!bus.i_stall) begin
            ifid_instr    <= bus.i_mem_data;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
            instr_count   <= instr_count + 32'd1;
            if (bus.i_mem_data == HALT_WORD) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HALTED: begin
          ifid_instr <= NOP_WORD;
          ifid_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.o_mem_addr      = {2'b00, pc[ADDR_LENGTH-1:2]};
  assign bus.o_pc            = pc;
  assign bus.o_ifid_instr    = ifid_instr;
  assign bus.o_ifid_pc_plus4 = ifid_pc_plus4;
  assign bus.o_ifid_valid    = ifid_valid;
  assign bus.o_halted        = halted;
  assign bus.o_instr_count   = instr_count;
  assign bus.o_fsm_state     = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, stall, redirect flush,
// wrong-path halt, enable freeze and asynchronous reset while halted.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [256];
  int          checks;
  int          errors;

  instruction_fetch_unit_if #(.ADDR_LENGTH(32), .DATA_LENGTH(32)) bus ();

  instruction_fetch_unit #(
    .ADDR_LENGTH(32),
    .DATA_LENGTH(32),
    .HALT_WORD  (32'hFFFF_FFFF),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  assign bus.i_mem_data = mem[bus.o_mem_addr[7:0]];

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_enable        = 1'b1;
    bus.i_stall         = 1'b0;
    bus.i_branch_taken  = 1'b0;
    bus.i_branch_target = '0;
    bus.i_jump          = 1'b0;
    bus.i_jump_target   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++; if (bus.o_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.o_pc, 32'd0); end
    checks++; if (bus.o_mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h want %h", bus.o_mem_addr, 32'd0); end
    checks++; if (bus.o_ifid_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", bus.o_ifid_instr, NOP); end
    checks++; if (bus.o_ifid_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc4: got %h want %h", bus.o_ifid_pc_plus4, 32'd0); end
    checks++; if (bus.o_ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_ifid_valid); end
    checks++; if (bus.o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.o_halted); end
    checks++; if (bus.o_instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.o_instr_count); end
    checks++; if (bus.o_fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", bus.o_fsm_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h2001_0001;
    exp_instr[1] = 32'h2002_0002;
    exp_instr[2] = 32'h2003_0003;
    exp_instr[3] = HALT;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.o_ifid_instr !== exp_instr[i]) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.o_ifid_instr, exp_instr[i]); end
      checks++; if (bus.o_ifid_pc_plus4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, bus.o_ifid_pc_plus4, 32'(4 * (i + 1))); end
      checks++; if (bus.o_ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.o_ifid_valid); end
      checks++; if (bus.o_halted !== (i == 3)) begin errors++; $display("FAIL seq_halted[%0d]: got %b want %b", i, bus.o_halted, (i == 3)); end
      checks++; if (bus.o_pc !== ((i == 3) ? 32'd12 : 32'(4 * (i + 1)))) begin errors++; $display("FAIL seq_pc[%0d]: got %h", i, bus.o_pc); end
      checks++; if (bus.o_instr_count !== 32'(i + 1)) begin errors++; $display("FAIL seq_count[%0d]: got %0d want %0d", i, bus.o_instr_count, i + 1); end
    end
    // Halted: bubbles, and a redirect is ignored.
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h0000_0040;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.o_ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_valid[%0d]: got %b want 0", i, bus.o_ifid_valid); end
      checks++; if (bus.o_ifid_instr !== NOP) begin errors++; $display("FAIL halt_instr[%0d]: got %h want %h", i, bus.o_ifid_instr, NOP); end
      checks++; if (bus.o_pc !== 32'd12) begin errors++; $display("FAIL halt_pc[%0d]: got %h want %h", i, bus.o_pc, 32'd12); end
      checks++; if (bus.o_instr_count !== 32'd4) begin errors++; $display("FAIL halt_count[%0d]: got %0d want 4", i, bus.o_instr_count); end
      checks++; if (bus.o_fsm_state !== 1'b1) begin errors++; $display("FAIL halt_state[%0d]: got %b want 1", i, bus.o_fsm_state); end
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    apply_reset();
    step();
    step();
    bus.i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.o_pc !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.o_pc, 32'd8); end
      checks++; if (bus.o_ifid_instr !== 32'h2002_0002) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, bus.o_ifid_instr, 32'h2002_0002); end
      checks++; if (bus.o_instr_count !== 32'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d want 2", i, bus.o_instr_count); end
    end
    bus.i_stall = 1'b0;
    step();
    checks++; if (bus.o_ifid_instr !== 32'h2003_0003) begin errors++; $display("FAIL stall_resume_instr: got %h want %h", bus.o_ifid_instr, 32'h2003_0003); end
    checks++; if (bus.o_ifid_pc_plus4 !== 32'd12) begin errors++; $display("FAIL stall_resume_pc4: got %h want %h", bus.o_ifid_pc_plus4, 32'd12); end
    step();
    checks++; if (bus.o_ifid_instr !== HALT) begin errors++; $display("FAIL stall_resume_halt: got %h want %h", bus.o_ifid_instr, HALT); end
    checks++; if (bus.o_halted !== 1'b1) begin errors++; $display("FAIL stall_resume_halted: got %b want 1", bus.o_halted); end
  endtask

  task automatic test_branch_flush();
    apply_reset();
    step();
    step();
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h0000_0043;
    bus.i_jump          = 1'b1;
    bus.i_jump_target   = 32'h0000_0080;
    bus.i_stall         = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.o_ifid_instr !== NOP) begin errors++; $display("FAIL br_instr: got %h want %h", bus.o_ifid_instr, NOP); end
    checks++; if (bus.o_ifid_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b want 0", bus.o_ifid_valid); end
    checks++; if (bus.o_pc !== 32'h40) begin errors++; $display("FAIL br_pc: got %h want %h", bus.o_pc, 32'h40); end
    checks++; if (bus.o_mem_addr !== 32'h10) begin errors++; $display("FAIL br_mem_addr: got %h want %h", bus.o_mem_addr, 32'h10); end
    checks++; if (bus.o_instr_count !== 32'd2) begin errors++; $display("FAIL br_count: got %0d want 2", bus.o_instr_count); end
    step();
    checks++; if (bus.o_ifid_instr !== 32'h2010_0010) begin errors++; $display("FAIL br_target_instr: got %h want %h", bus.o_ifid_instr, 32'h2010_0010); end
    checks++; if (bus.o_ifid_pc_plus4 !== 32'h44) begin errors++; $display("FAIL br_target_pc4: got %h want %h", bus.o_ifid_pc_plus4, 32'h44); end
    checks++; if (bus.o_ifid_valid !== 1'b1) begin errors++; $display("FAIL br_target_valid: got %b want 1", bus.o_ifid_valid); end
    checks++; if (bus.o_instr_count !== 32'd3) begin errors++; $display("FAIL br_target_count: got %0d want 3", bus.o_instr_count); end
  endtask

  task automatic test_wrong_path_halt();
    apply_reset();
    step();
    step();
    step();
    bus.i_jump        = 1'b1;
    bus.i_jump_target = 32'h0000_0020;
    step();
    idle_inputs();
    checks++; if (bus.o_halted !== 1'b0) begin errors++; $display("FAIL wp_halted: got %b want 0", bus.o_halted); end
    checks++; if (bus.o_pc !== 32'h20) begin errors++; $display("FAIL wp_pc: got %h want %h", bus.o_pc, 32'h20); end
    checks++; if (bus.o_instr_count !== 32'd3) begin errors++; $display("FAIL wp_count: got %0d want 3", bus.o_instr_count); end
    checks++; if (bus.o_ifid_valid !== 1'b0) begin errors++; $display("FAIL wp_valid: got %b want 0", bus.o_ifid_valid); end
    step();
    checks++; if (bus.o_ifid_instr !== 32'h2008_0008) begin errors++; $display("FAIL wp_next_instr: got %h want %h", bus.o_ifid_instr, 32'h2008_0008); end
    checks++; if (bus.o_instr_count !== 32'd4) begin errors++; $display("FAIL wp_next_count: got %0d want 4", bus.o_instr_count); end
  endtask

  task automatic test_enable_freeze();
    apply_reset();
    step();
    step();
    bus.i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_branch_taken  = (i == 2);
      bus.i_branch_target = 32'h0000_0040;
      step();
      checks++; if (bus.o_pc !== 32'd8) begin errors++; $display("FAIL frz_pc[%0d]: got %h want %h", i, bus.o_pc, 32'd8); end
      checks++; if (bus.o_ifid_instr !== 32'h2002_0002) begin errors++; $display("FAIL frz_instr[%0d]: got %h want %h", i, bus.o_ifid_instr, 32'h2002_0002); end
      checks++; if (bus.o_ifid_pc_plus4 !== 32'd8) begin errors++; $display("FAIL frz_pc4[%0d]: got %h want %h", i, bus.o_ifid_pc_plus4, 32'd8); end
      checks++; if (bus.o_ifid_valid !== 1'b1) begin errors++; $display("FAIL frz_valid[%0d]: got %b want 1", i, bus.o_ifid_valid); end
      checks++; if (bus.o_instr_count !== 32'd2) begin errors++; $display("FAIL frz_count[%0d]: got %0d want 2", i, bus.o_instr_count); end
    end
    idle_inputs();
    step();
    checks++; if (bus.o_ifid_instr !== 32'h2003_0003) begin errors++; $display("FAIL frz_resume_instr: got %h want %h", bus.o_ifid_instr, 32'h2003_0003); end
    checks++; if (bus.o_pc !== 32'd12) begin errors++; $display("FAIL frz_resume_pc: got %h want %h", bus.o_pc, 32'd12); end
  endtask

  task automatic test_async_reset_halted();
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.o_halted !== 1'b1) begin errors++; $display("FAIL ar_pre_halted: got %b want 1", bus.o_halted); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_halted !== 1'b0) begin errors++; $display("FAIL ar_halted: got %b want 0", bus.o_halted); end
    checks++; if (bus.o_pc !== 32'd0) begin errors++; $display("FAIL ar_pc: got %h want 0", bus.o_pc); end
    checks++; if (bus.o_ifid_instr !== NOP) begin errors++; $display("FAIL ar_instr: got %h want %h", bus.o_ifid_instr, NOP); end
    checks++; if (bus.o_ifid_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.o_ifid_valid); end
    checks++; if (bus.o_ifid_pc_plus4 !== 32'd0) begin errors++; $display("FAIL ar_pc4: got %h want 0", bus.o_ifid_pc_plus4); end
    checks++; if (bus.o_instr_count !== 32'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", bus.o_instr_count); end
    checks++; if (bus.o_fsm_state !== 1'b0) begin errors++; $display("FAIL ar_state: got %b want 0", bus.o_fsm_state); end
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (bus.o_ifid_instr !== 32'h2001_0001) begin errors++; $display("FAIL ar_restart_instr: got %h want %h", bus.o_ifid_instr, 32'h2001_0001); end
    checks++; if (bus.o_ifid_pc_plus4 !== 32'd4) begin errors++; $display("FAIL ar_restart_pc4: got %h want 4", bus.o_ifid_pc_plus4); end
    checks++; if (bus.o_instr_count !== 32'd1) begin errors++; $display("FAIL ar_restart_count: got %0d want 1", bus.o_instr_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[0]  = 32'h2001_0001;
    mem[1]  = 32'h2002_0002;
    mem[2]  = 32'h2003_0003;
    mem[3]  = HALT;
    mem[8]  = 32'h2008_0008;
    mem[16] = 32'h2010_0010;
    mem[17] = 32'h2011_0011;

    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_wrong_path_halt();
    test_enable_freeze();
    test_async_reset_halted();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
